// File: rtl/edge_word_writer_if.sv
// Pixel stream in, packed-word write stream out, for edge_word_writer.
interface edge_word_writer_if #(
  parameter int WORD_W = 32
);
  logic              pix_valid;
  logic              pix_bit;
  logic              pix_ready;
  logic              wr_req;
  logic [31:0]       wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ack;

  // Block side: consumes pixels, masters the SRAM write stream.
  modport master (
    input  pix_valid, pix_bit, wr_ack,
    output pix_ready, wr_req, wr_addr, wr_data
  );

  // Environment side: produces pixels, acknowledges writes.
  modport slave (
    output pix_valid, pix_bit, wr_ack,
    input  pix_ready, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/edge_word_writer.sv
// Packs a 1-bit edge stream into WORD_W-bit words (MSB = leftmost pixel),
// queues {addr,data} in a small FIFO and writes a completion flag per frame.
module edge_word_writer #(
  parameter int          WORD_W     = 32,
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter int          FIFO_DEPTH = 4,
  parameter int          SERPENTINE = 1,
  parameter logic [31:0] ADDR_STEP  = 32'd4,
  parameter logic [31:0] DONE_ADDR  = 32'd4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                img_start,
  input  logic [31:0]         base_addr,
  edge_word_writer_if.master  bus,
  output logic                busy,
  output logic                img_done
);
  localparam int LOG_W = $clog2(WORD_W);
  localparam int WPR   = (IMG_W + WORD_W - 1) / WORD_W;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLAG, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [WORD_W-1:0] pack;
  logic [31:0]       base_q;

  logic [31:0]       fifo_addr [FIFO_DEPTH];
  logic [WORD_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;

  logic              start_ok, fifo_full, fifo_empty, fifo_req;
  logic              accept, reverse, word_end, push, pop;
  logic              col_last, row_last, last_pix;
  logic [31:0]       x, word_idx, push_addr;
  logic [LOG_W-1:0]  sub;
  logic [WORD_W-1:0] pix_word;

  // Pixel position, packing and push decision for the current pixel.
  always_comb begin
    start_ok   = img_start & ((state == S_IDLE) | (state == S_DONE));
    fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count == '0);
    fifo_req   = !fifo_empty & ((state == S_RUN) | (state == S_DRAIN));
    accept     = bus.pix_valid & (state == S_RUN) & !fifo_full;
    reverse    = (SERPENTINE != 0) & row[0];
    x          = reverse ? (32'(IMG_W - 1) - 32'(col)) : 32'(col);
    sub        = x[LOG_W-1:0];
    word_idx   = x >> LOG_W;
    // Bit WORD_W-1-sub is exactly ~sub for a power-of-two word width.
    pix_word   = WORD_W'(bus.pix_bit) << (~sub);
    word_end   = reverse ? (sub == '0)
                         : ((sub == '1) | (x == 32'(IMG_W - 1)));
    push       = accept & word_end;
    pop        = fifo_req & bus.wr_ack;
    col_last   = (col == COL_W'(IMG_W - 1));
    row_last   = (row == ROW_W'(IMG_H - 1));
    last_pix   = accept & col_last & row_last;
    push_addr  = base_q + (32'(row) * 32'(WPR) + word_idx) * ADDR_STEP;
  end

  // Next-state logic and output decode.
  always_comb begin
    state_nxt     = state;
    bus.pix_ready = (state == S_RUN) & !fifo_full;
    bus.wr_req    = fifo_req | (state == S_FLAG);
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    busy          = (state != S_IDLE) & (state != S_DONE);
    img_done      = (state == S_DONE);
    if (fifo_req) begin
      bus.wr_addr = fifo_addr[rptr];
      bus.wr_data = fifo_data[rptr];
    end else if (state == S_FLAG) begin
      bus.wr_addr = DONE_ADDR;
      bus.wr_data = WORD_W'(1);
    end
    unique case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (last_pix) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nxt = S_FLAG;
      S_FLAG:  if (bus.wr_ack) state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Frame position, base address and partial-word pack register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col    <= '0;
      row    <= '0;
      pack   <= '0;
      base_q <= '0;
    end else if (start_ok) begin
      col    <= '0;
      row    <= '0;
      pack   <= '0;
      base_q <= base_addr;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      pack <= push ? '0 : (pack | pix_word);
    end
  end

  // Write FIFO pointers and count; reset discards any queued words.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; completed word includes the completing pixel.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= push_addr;
      fifo_data[wptr] <= pack | pix_word;
    end
  end
endmodule

// File: tb/tb_edge_word_writer.sv
// Bench for edge_word_writer: two instances (serpentine 40x2, raster 64x4).
module tb_edge_word_writer;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0]       base;
    logic [39:0]       r0;  // bit 39 = first-arriving pixel of row 0
    logic [39:0]       r1;  // bit 39 = first-arriving pixel of row 1
    logic [3:0][31:0]  d;   // expected data in write order
  } frame_t;

  logic        clk = 1'b0;
  logic        n_rst [2];
  logic        img_start [2];
  logic [31:0] base_addr [2];
  logic        pix_valid [2];
  logic        pix_bit [2];
  logic        wr_ack [2];
  int          ack_mode [2];
  logic        ready [2];
  logic        req [2];
  logic [31:0] addr [2];
  logic [31:0] data [2];
  logic        busy [2];
  logic        done [2];

  int passes = 0;
  int checks = 0;
  wr_t exp_q [2][$];

  always #5 clk = ~clk;

  edge_word_writer_if #(.WORD_W(32)) bus_a ();
  edge_word_writer_if #(.WORD_W(32)) bus_b ();

  assign bus_a.pix_valid = pix_valid[0];
  assign bus_a.pix_bit   = pix_bit[0];
  assign bus_a.wr_ack    = wr_ack[0];
  assign ready[0] = bus_a.pix_ready;
  assign req[0]   = bus_a.wr_req;
  assign addr[0]  = bus_a.wr_addr;
  assign data[0]  = bus_a.wr_data;

  assign bus_b.pix_valid = pix_valid[1];
  assign bus_b.pix_bit   = pix_bit[1];
  assign bus_b.wr_ack    = wr_ack[1];
  assign ready[1] = bus_b.pix_ready;
  assign req[1]   = bus_b.wr_req;
  assign addr[1]  = bus_b.wr_addr;
  assign data[1]  = bus_b.wr_data;

  edge_word_writer #(
    .WORD_W(32), .IMG_W(40), .IMG_H(2), .FIFO_DEPTH(4), .SERPENTINE(1),
    .ADDR_STEP(32'd4), .DONE_ADDR(32'd4)
  ) dut_a (
    .clk(clk), .n_rst(n_rst[0]), .img_start(img_start[0]), .base_addr(base_addr[0]),
    .bus(bus_a), .busy(busy[0]), .img_done(done[0])
  );

  edge_word_writer #(
    .WORD_W(32), .IMG_W(64), .IMG_H(4), .FIFO_DEPTH(4), .SERPENTINE(0),
    .ADDR_STEP(32'd4), .DONE_ADDR(32'd4)
  ) dut_b (
    .clk(clk), .n_rst(n_rst[1]), .img_start(img_start[1]), .base_addr(base_addr[1]),
    .bus(bus_b), .busy(busy[1]), .img_done(done[1])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic fail_bound(input string name);
    checks++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  // Write acknowledger: 0 = never, 1 = random, 2 = always.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      wr_ack[i] = (ack_mode[i] == 2) ? 1'b1 :
                  (ack_mode[i] == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
  end

  // Scoreboard monitor: every consumed write must match the queue head;
  // a stalled request must hold its address and data.
  logic        hold [2] = '{1'b0, 1'b0};
  logic [31:0] hold_a [2];
  logic [31:0] hold_d [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (hold[i] && req[i]) begin
        check("stall_hold_addr", 64'(addr[i]), 64'(hold_a[i]));
        check("stall_hold_data", 64'(data[i]), 64'(hold_d[i]));
      end
      if (req[i] && wr_ack[i]) begin
        if (exp_q[i].size() == 0) begin
          check("unexpected_write_addr", 64'(addr[i]), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q[i].pop_front();
          check("write_addr", 64'(addr[i]), 64'(e.a));
          check("write_data", 64'(data[i]), 64'(e.d));
        end
      end
      hold[i]   = req[i] && !wr_ack[i] && n_rst[i];
      hold_a[i] = addr[i];
      hold_d[i] = data[i];
    end
  end

  task automatic expect_wr(input int i, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q[i].push_back(e);
  endtask

  task automatic send(input int i, input logic b);
    logic got;
    got = 1'b0;
    pix_valid[i] = 1'b1;
    pix_bit[i]   = b;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_bound("pix_accept");
    @(posedge clk);
    #1;
    pix_valid[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i, input logic [31:0] b);
    img_start[i] = 1'b1;
    base_addr[i] = b;
    @(posedge clk);
    #1;
    img_start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_bound("img_done");
  endtask

  function automatic frame_t mk(input logic [31:0] b, input logic [39:0] r0, input logic [39:0] r1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
    frame_t f;
    f.base = b;
    f.r0   = r0;
    f.r1   = r1;
    f.d[0] = d0;
    f.d[1] = d1;
    f.d[2] = d2;
    f.d[3] = d3;
    return f;
  endfunction

  frame_t frames [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_rst[i] = 1'b0; img_start[i] = 1'b0; base_addr[i] = '0;
      pix_valid[i] = 1'b0; pix_bit[i] = 1'b0; wr_ack[i] = 1'b0; ack_mode[i] = 0;
    end

    // Row 0 forward: words x0..31, x32..39. Row 1 reversed: x39..32 word first.
    frames[0] = mk(32'h0000_0100, 40'hFF_FFFF_FFFF, 40'h80_0000_0000,
                   32'hFFFF_FFFF, 32'hFF00_0000, 32'h0100_0000, 32'h0000_0000);
    frames[1] = mk(32'h0000_2000, 40'h80_0000_0001, 40'h00_0000_0001,
                   32'h8000_0000, 32'h0100_0000, 32'h0000_0000, 32'h8000_0000);
    frames[2] = mk(32'hFFFF_FFF8, 40'h00_0000_0000, 40'hFF_FFFF_FFFF,
                   32'h0000_0000, 32'h0000_0000, 32'hFF00_0000, 32'hFFFF_FFFF);
    frames[3] = mk(32'h0000_0040, 40'hAA_AAAA_AAAA, 40'hF0_0000_000F,
                   32'hAAAA_AAAA, 32'hAA00_0000, 32'h0F00_0000, 32'hF000_0000);

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_wr_req", 64'(req[i]), 64'd0);
      check("rst_wr_addr", 64'(addr[i]), 64'd0);
      check("rst_wr_data", 64'(data[i]), 64'd0);
      check("rst_pix_ready", 64'(ready[i]), 64'd0);
      check("rst_busy", 64'(busy[i]), 64'd0);
      check("rst_img_done", 64'(done[i]), 64'd0);
    end
    #2;
    n_rst[0] = 1'b1;
    n_rst[1] = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames on the serpentine instance with random acks.
    ack_mode[0] = 1;
    for (int f = 0; f < 4; f++) begin
      pulse_start(0, frames[f].base);
      @(negedge clk);
      check("start_busy", 64'(busy[0]), 64'd1);
      check("start_clears_done", 64'(done[0]), 64'd0);
      expect_wr(0, frames[f].base,          frames[f].d[0]);
      expect_wr(0, frames[f].base + 32'd4,  frames[f].d[1]);
      expect_wr(0, frames[f].base + 32'd12, frames[f].d[2]);
      expect_wr(0, frames[f].base + 32'd8,  frames[f].d[3]);
      expect_wr(0, 32'd4, 32'd1);
      @(posedge clk);
      #1;
      for (int p = 0; p < 40; p++) begin
        if (p == 20) pulse_start(0, 32'hDEAD_0000);
        send(0, frames[f].r0[39 - p]);
      end
      for (int p = 0; p < 40; p++) send(0, frames[f].r1[39 - p]);
      wait_done(0);
      check("frame_done", 64'(done[0]), 64'd1);
      check("frame_not_busy", 64'(busy[0]), 64'd0);
      check("frame_queue_empty", 64'(exp_q[0].size()), 64'd0);
    end

    // Raster instance: first-word latency, back-pressure, then drain.
    ack_mode[1] = 0;
    pulse_start(1, 32'h0000_0300);
    for (int k = 0; k < 8; k++) expect_wr(1, 32'h0000_0300 + 32'(4 * k), 32'hAAAA_AAAA);
    expect_wr(1, 32'd4, 32'd1);
    for (int p = 0; p < 31; p++) send(1, ~p[0]);
    @(negedge clk);
    check("no_req_before_word", 64'(req[1]), 64'd0);
    @(posedge clk);
    #1;
    send(1, 1'b0);
    @(negedge clk);
    check("req_after_first_word", 64'(req[1]), 64'd1);
    @(posedge clk);
    #1;
    for (int p = 32; p < 128; p++) send(1, ~p[0]);
    @(negedge clk);
    check("full_pix_ready", 64'(ready[1]), 64'd0);
    repeat (5) @(negedge clk);
    check("full_still_not_ready", 64'(ready[1]), 64'd0);
    check("stall_head_addr", 64'(addr[1]), 64'h300);
    check("stall_head_data", 64'(data[1]), 64'hAAAA_AAAA);
    ack_mode[1] = 1;
    @(posedge clk);
    #1;
    for (int p = 128; p < 256; p++) send(1, ~p[0]);
    wait_done(1);
    check("raster_done", 64'(done[1]), 64'd1);
    check("raster_queue_empty", 64'(exp_q[1].size()), 64'd0);

    // Reset with three words queued on the serpentine instance.
    ack_mode[0] = 0;
    @(posedge clk);
    #1;
    pulse_start(0, 32'h0000_0500);
    for (int p = 0; p < 48; p++) send(0, 1'b1);
    @(negedge clk);
    check("queued_req", 64'(req[0]), 64'd1);
    check("queued_head_addr", 64'(addr[0]), 64'h500);
    @(posedge clk);
    #1;
    n_rst[0] = 1'b0;
    @(negedge clk);
    check("midrst_wr_req", 64'(req[0]), 64'd0);
    check("midrst_img_done", 64'(done[0]), 64'd0);
    check("midrst_busy", 64'(busy[0]), 64'd0);
    check("midrst_wr_addr", 64'(addr[0]), 64'd0);
    #2;
    n_rst[0] = 1'b1;
    ack_mode[0] = 1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (req[0]) seen++;
      end
      check("post_rst_no_write", 64'(seen), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
